// File: rtl/qubit_state_bank.sv
// Bank of single-qubit state registers with a valid/ready write port, a registered read port,
// a |0> re-initialisation sweep and a two-stage normalisation checker on accepted writes.
module qubit_state_bank #(
  parameter int NUM_QUBITS = 4,
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int NORM_TOL   = 4,
  localparam int AW        = $clog2(NUM_QUBITS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_req,
  output logic              init_busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_alpha_re,
  input  logic [DATA_W-1:0] wr_alpha_im,
  input  logic [DATA_W-1:0] wr_beta_re,
  input  logic [DATA_W-1:0] wr_beta_im,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_alpha_re,
  output logic [DATA_W-1:0] rd_alpha_im,
  output logic [DATA_W-1:0] rd_beta_re,
  output logic [DATA_W-1:0] rd_beta_im,
  output logic              norm_err,
  output logic [AW-1:0]     norm_err_addr,
  input  logic              norm_clr
);

  localparam int ENT_W = 4 * DATA_W;
  localparam int SQ_W  = 2 * DATA_W;
  localparam int SUM_W = 2 * DATA_W + 2;
  localparam logic [ENT_W-1:0] KET_ZERO = {DATA_W'(1) << FRAC_W, {(3*DATA_W){1'b0}}};
  localparam logic [AW:0]      NQ_L     = (AW+1)'(NUM_QUBITS);
  localparam logic [SUM_W-1:0] ONE_N    = SUM_W'(1) << FRAC_W;
  localparam logic [SUM_W-1:0] TOL_N    = SUM_W'(NORM_TOL);

  typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic            sweep_en;
  logic            wr_fire;
  logic            wr_in_range;
  logic            rd_in_range;
  logic [ENT_W-1:0] wr_data;
  logic [ENT_W-1:0] entry_q [NUM_QUBITS];
  logic [ENT_W-1:0] rd_data_reg;
  logic            rd_valid_reg;

  logic signed [SQ_W-1:0] sq_next [4];
  logic signed [SQ_W-1:0] sq_reg  [4];
  logic            s1_valid_reg;
  logic [AW-1:0]   s1_addr_reg;
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W-1:0] norm_next;
  logic [SUM_W-1:0] diff_next;
  logic            s2_valid_reg;
  logic            s2_err_reg;
  logic [AW-1:0]   s2_addr_reg;
  logic            norm_err_reg;
  logic [AW-1:0]   norm_err_addr_reg;

  // ---------------- sweep FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (init_req) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      INIT: begin
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == AW'(NUM_QUBITS - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // init_req blocks the write in the same cycle so the sweep always wins.
  always_comb begin
    init_busy = (state_reg == INIT);
    sweep_en  = (state_reg == INIT);
    wr_ready  = reset_n && (state_reg == IDLE) && !init_req;
  end

  // ---------------- storage ----------------
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = {1'b0, wr_addr} < NQ_L;
  assign rd_in_range = {1'b0, rd_addr} < NQ_L;
  assign wr_data     = {wr_alpha_re, wr_alpha_im, wr_beta_re, wr_beta_im};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUBITS; gi++) begin : g_entry
      logic [ENT_W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          entry_reg <= KET_ZERO;
        end else if (sweep_en && cnt_reg == AW'(gi)) begin
          entry_reg <= KET_ZERO;
        end else if (wr_fire && wr_in_range && wr_addr == AW'(gi)) begin
          entry_reg <= wr_data;
        end
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // Reads sample entry_q before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_data_reg <= rd_in_range ? entry_q[rd_addr] : '0;
      end
    end
  end

  assign rd_valid    = rd_valid_reg;
  assign rd_alpha_re = rd_data_reg[4*DATA_W-1 -: DATA_W];
  assign rd_alpha_im = rd_data_reg[3*DATA_W-1 -: DATA_W];
  assign rd_beta_re  = rd_data_reg[2*DATA_W-1 -: DATA_W];
  assign rd_beta_im  = rd_data_reg[DATA_W-1 -: DATA_W];

  // ---------------- normalisation checker ----------------
  generate
    for (gi = 0; gi < 4; gi++) begin : g_square
      assign sq_next[gi] = $signed(wr_data[(4-gi)*DATA_W-1 -: DATA_W])
                         * $signed(wr_data[(4-gi)*DATA_W-1 -: DATA_W]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      for (int k = 0; k < 4; k++) sq_reg[k] <= '0;
    end else begin
      s1_valid_reg <= wr_fire && wr_in_range;
      if (wr_fire && wr_in_range) begin
        s1_addr_reg <= wr_addr;
        for (int k = 0; k < 4; k++) sq_reg[k] <= sq_next[k];
      end
    end
  end

  // Squares are never negative, so they are summed as unsigned values.
  always_comb begin
    sum_next = '0;
    for (int k = 0; k < 4; k++) sum_next = sum_next + {2'b00, sq_reg[k]};
    norm_next = sum_next >> FRAC_W;
    diff_next = (norm_next >= ONE_N) ? (norm_next - ONE_N) : (ONE_N - norm_next);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid_reg <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_addr_reg  <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_err_reg   <= diff_next > TOL_N;
      s2_addr_reg  <= s1_addr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      norm_err_reg      <= 1'b0;
      norm_err_addr_reg <= '0;
    end else if (s2_valid_reg && s2_err_reg) begin
      norm_err_reg <= 1'b1;
      if (!norm_err_reg || norm_clr) norm_err_addr_reg <= s2_addr_reg;
    end else if (norm_clr) begin
      norm_err_reg <= 1'b0;
    end
  end

  assign norm_err      = norm_err_reg;
  assign norm_err_addr = norm_err_addr_reg;

endmodule

// File: tb/tb_qubit_state_bank.sv
// Bench for qubit_state_bank: vector table, hand sequences for multi-cycle corners and a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_qubit_state_bank;
  localparam int NQ  = 4;
  localparam int DW  = 16;
  localparam int FW  = 8;
  localparam int TOL = 4;
  localparam int AW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, init_req, wr_valid, rd_en, norm_clr;
  logic init_busy, wr_ready, rd_valid, norm_err;
  logic [AW-1:0] wr_addr, rd_addr, norm_err_addr;
  logic [DW-1:0] wr_alpha_re, wr_alpha_im, wr_beta_re, wr_beta_im;
  logic [DW-1:0] rd_alpha_re, rd_alpha_im, rd_beta_re, rd_beta_im;

  qubit_state_bank #(.NUM_QUBITS(NQ), .DATA_W(DW), .FRAC_W(FW), .NORM_TOL(TOL)) dut (
    .clk(clk), .reset_n(reset_n), .init_req(init_req), .init_busy(init_busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_alpha_re(wr_alpha_re), .wr_alpha_im(wr_alpha_im),
    .wr_beta_re(wr_beta_re), .wr_beta_im(wr_beta_im),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_alpha_re(rd_alpha_re), .rd_alpha_im(rd_alpha_im),
    .rd_beta_re(rd_beta_re), .rd_beta_im(rd_beta_im),
    .norm_err(norm_err), .norm_err_addr(norm_err_addr), .norm_clr(norm_clr)
  );

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: component order alpha_re, alpha_im, beta_re, beta_im.
  typedef struct { int due; int addr; bit err; } chk_t;
  logic [DW-1:0] m_mem [NQ][4];
  logic [DW-1:0] m_rd [4];
  bit  m_rd_valid;
  bit  m_err;
  int  m_err_addr;
  int  m_busy;
  int  edge_no = 0;
  chk_t pend[$];

  typedef struct { int addr; logic [DW-1:0] ar, ai, br, bi; bit err; } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit norm_bad(input logic [DW-1:0] ar, ai, br, bi);
    longint s, n, d;
    s = longint'($signed(ar)) * longint'($signed(ar)) + longint'($signed(ai)) * longint'($signed(ai))
      + longint'($signed(br)) * longint'($signed(br)) + longint'($signed(bi)) * longint'($signed(bi));
    n = s / (longint'(1) << FW);
    d = n - (longint'(1) << FW);
    if (d < 0) d = -d;
    return d > TOL;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) begin
      m_mem[i][0] = DW'(1) << FW;
      for (int k = 1; k < 4; k++) m_mem[i][k] = '0;
    end
    for (int k = 0; k < 4; k++) m_rd[k] = '0;
    m_rd_valid = 0; m_err = 0; m_err_addr = 0; m_busy = 0;
    pend.delete();
  endtask

  // One clock: check combinational outputs, step the model at the edge, check registered outputs.
  task automatic tick();
    bit ready, set;
    int sa;
    chk_t c;
    #1;
    ready = reset_n && (m_busy == 0) && !init_req;
    check("wr_ready", wr_ready, ready);
    check("init_busy_pre", init_busy, m_busy > 0);
    @(posedge clk);
    edge_no++;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) begin
        for (int k = 0; k < 4; k++) m_rd[k] = (int'(rd_addr) < NQ) ? m_mem[rd_addr][k] : '0;
      end
      set = 0; sa = 0;
      while (pend.size() > 0 && pend[0].due == edge_no) begin
        c = pend.pop_front();
        if (c.err) begin set = 1; sa = c.addr; end
      end
      if (set) begin
        if (!m_err || norm_clr) m_err_addr = sa;
        m_err = 1;
      end else if (norm_clr) begin
        m_err = 0;
      end
      if (ready && wr_valid && int'(wr_addr) < NQ) begin
        m_mem[wr_addr][0] = wr_alpha_re; m_mem[wr_addr][1] = wr_alpha_im;
        m_mem[wr_addr][2] = wr_beta_re;  m_mem[wr_addr][3] = wr_beta_im;
        pend.push_back('{edge_no + 2, int'(wr_addr),
                         norm_bad(wr_alpha_re, wr_alpha_im, wr_beta_re, wr_beta_im)});
        $display("wr addr=%0d data=%h %h %h %h", wr_addr, wr_alpha_re, wr_alpha_im, wr_beta_re, wr_beta_im);
      end
      if (m_busy > 0) begin
        m_mem[NQ - m_busy][0] = DW'(1) << FW;
        for (int k = 1; k < 4; k++) m_mem[NQ - m_busy][k] = '0;
        m_busy--;
      end else if (init_req) begin
        m_busy = NQ;
      end
    end
    #1;
    check("rd_valid", rd_valid, m_rd_valid);
    check("rd_alpha_re", rd_alpha_re, m_rd[0]);
    check("rd_alpha_im", rd_alpha_im, m_rd[1]);
    check("rd_beta_re", rd_beta_re, m_rd[2]);
    check("rd_beta_im", rd_beta_im, m_rd[3]);
    check("norm_err", norm_err, m_err);
    check("norm_err_addr", norm_err_addr, m_err_addr);
    check("init_busy_post", init_busy, m_busy > 0);
    if (rd_valid) $display("rd data=%h %h %h %h", rd_alpha_re, rd_alpha_im, rd_beta_re, rd_beta_im);
  endtask

  task automatic set_wr(input int a, input logic [DW-1:0] ar, ai, br, bi);
    wr_valid = 1; wr_addr = AW'(a);
    wr_alpha_re = ar; wr_alpha_im = ai; wr_beta_re = br; wr_beta_im = bi;
  endtask

  task automatic write_one(input int a, input logic [DW-1:0] ar, ai, br, bi);
    set_wr(a, ar, ai, br, bi);
    tick();
    wr_valid = 0;
  endtask

  task automatic read_one(input int a);
    rd_en = 1; rd_addr = AW'(a);
    tick();
    rd_en = 0;
  endtask

  task automatic clear_err();
    norm_clr = 1; tick(); norm_clr = 0;
  endtask

  task automatic rand_write_data();
    logic [DW-1:0] d;
    case ($urandom_range(0, 5))
      0: set_wr($urandom_range(0, NQ-1), 16'h0100, 16'h0000, 16'h0000, 16'h0000);
      1: set_wr($urandom_range(0, NQ-1), 16'h0000, 16'h0000, 16'h0000, 16'hFF00);
      2: set_wr($urandom_range(0, NQ-1), 16'h00B5, 16'h0000, 16'hFF4B, 16'h0000);
      3: begin
        d = DW'(16'h00FC + $urandom_range(0, 8));
        set_wr($urandom_range(0, NQ-1), 16'h0000, d, 16'h0000, 16'h0000);
      end
      default: set_wr($urandom_range(0, NQ-1), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    endcase
  endtask

  initial begin
    int busy_cycles;
    vecs[0] = '{2, 16'h00B5, 16'h0000, 16'h00B5, 16'h0000, 1'b0};
    vecs[1] = '{0, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{3, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0};
    vecs[3] = '{1, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b1};
    vecs[4] = '{3, 16'h0080, 16'h0000, 16'h0080, 16'h0000, 1'b1};
    vecs[5] = '{1, 16'h0102, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{2, 16'h0103, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{0, 16'h0000, 16'h00FE, 16'h0000, 16'h0000, 1'b0};
    vecs[8] = '{1, 16'h0000, 16'h0000, 16'hFF03, 16'h0000, 1'b1};
    vecs[9] = '{2, 16'h0100, 16'h0000, 16'h0000, 16'h0004, 1'b0};

    reset_n = 0; init_req = 0; wr_valid = 0; rd_en = 0; norm_clr = 0;
    wr_addr = '0; rd_addr = '0;
    wr_alpha_re = '0; wr_alpha_im = '0; wr_beta_re = '0; wr_beta_im = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_init_busy", init_busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_norm_err", norm_err, 0);
    check("rst_wr_ready", wr_ready, 0);
    reset_n = 1;

    // Every entry comes out of reset as |0>.
    for (int i = 0; i < NQ; i++) begin
      read_one(i);
      check($sformatf("rst_rd%0d_valid", i), rd_valid, 1);
      check($sformatf("rst_rd%0d_are", i), rd_alpha_re, 16'h0100);
      check($sformatf("rst_rd%0d_bre", i), rd_beta_re, 16'h0000);
      tick();
      check($sformatf("rst_rd%0d_valid_drop", i), rd_valid, 0);
    end

    // Vector table: write, read back next cycle, norm verdict two edges after acceptance.
    foreach (vecs[i]) begin
      clear_err();
      write_one(vecs[i].addr, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi);
      read_one(vecs[i].addr);
      check($sformatf("vec%0d_are", i), rd_alpha_re, vecs[i].ar);
      check($sformatf("vec%0d_aim", i), rd_alpha_im, vecs[i].ai);
      check($sformatf("vec%0d_bre", i), rd_beta_re, vecs[i].br);
      check($sformatf("vec%0d_bim", i), rd_beta_im, vecs[i].bi);
      tick();
      check($sformatf("vec%0d_norm_err", i), norm_err, vecs[i].err);
      if (vecs[i].err) check($sformatf("vec%0d_err_addr", i), norm_err_addr, vecs[i].addr);
    end

    // Sticky error flag, first address kept, set beats clear on the same edge.
    clear_err();
    write_one(1, 16'h0100, 16'h0000, 16'h0100, 16'h0000);
    tick();
    check("sticky_not_yet", norm_err, 0);
    tick();
    check("sticky_set", norm_err, 1);
    check("sticky_addr1", norm_err_addr, 1);
    write_one(3, 16'h0100, 16'h0000, 16'h0100, 16'h0000);
    tick(); tick();
    check("sticky_keep_addr", norm_err_addr, 1);
    write_one(2, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
    tick();
    norm_clr = 1; tick(); norm_clr = 0;
    check("set_beats_clr", norm_err, 1);
    check("set_beats_clr_addr", norm_err_addr, 2);
    clear_err();
    check("clr_works", norm_err, 0);

    // Sweep: load |1> everywhere, sweep, with a write held throughout.
    for (int i = 0; i < NQ; i++) write_one(i, 16'h0000, 16'h0000, 16'h0100, 16'h0000);
    init_req = 1; tick(); init_req = 0;
    set_wr(2, 16'h00B5, 16'h0000, 16'h00B5, 16'h0000);
    busy_cycles = 0;
    while (init_busy === 1'b1 && busy_cycles < 3 * NQ) begin
      busy_cycles++;
      tick();
    end
    check("sweep_len", busy_cycles, NQ);
    check("ready_after_sweep", wr_ready, 1);
    tick();
    wr_valid = 0;
    for (int i = 0; i < NQ; i++) begin
      read_one(i);
      check($sformatf("sweep_rd%0d_are", i), rd_alpha_re, (i == 2) ? 16'h00B5 : 16'h0100);
      check($sformatf("sweep_rd%0d_bre", i), rd_beta_re, (i == 2) ? 16'h00B5 : 16'h0000);
    end

    // Same-edge read and write to one address returns the old contents.
    write_one(0, 16'h0000, 16'h0000, 16'h0100, 16'h0000);
    set_wr(0, 16'hFF00, 16'h0000, 16'h0000, 16'h0000);
    rd_en = 1; rd_addr = '0;
    tick();
    wr_valid = 0; rd_en = 0;
    check("rbw_old_are", rd_alpha_re, 16'h0000);
    check("rbw_old_bre", rd_beta_re, 16'h0100);
    read_one(0);
    check("rbw_new_are", rd_alpha_re, 16'hFF00);

    // Reset with a bad check in flight discards it.
    write_one(1, 16'h0100, 16'h0000, 16'h0100, 16'h0000);
    reset_n = 0; tick(); reset_n = 1;
    tick(); tick();
    check("rst_discard_norm", norm_err, 0);

    // Reset mid-sweep aborts it and leaves every entry at |0>.
    write_one(3, 16'h0000, 16'h0000, 16'h0100, 16'h0000);
    init_req = 1; tick(); init_req = 0;
    tick();
    reset_n = 0; tick(); reset_n = 1;
    check("rst_mid_sweep_busy", init_busy, 0);
    for (int i = 0; i < NQ; i++) begin
      read_one(i);
      check($sformatf("rst_sweep_rd%0d_are", i), rd_alpha_re, 16'h0100);
      check($sformatf("rst_sweep_rd%0d_bre", i), rd_beta_re, 16'h0000);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      reset_n  = ($urandom_range(0, 199) != 0);
      init_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) rand_write_data();
      else wr_valid = 0;
      rd_en    = $urandom_range(0, 1);
      rd_addr  = AW'($urandom_range(0, NQ-1));
      norm_clr = ($urandom_range(0, 9) == 0);
      tick();
    end
    reset_n = 1; init_req = 0; wr_valid = 0; rd_en = 0; norm_clr = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/qubit_state_bank.md
Name: qubit_state_bank

Overview:
- Parametrised bank of NUM_QUBITS single-qubit state registers. Each entry holds alpha = (alpha_re + i·alpha_im) and beta = (beta_re + i·beta_im) in signed fixed point.
- Adds four things a single register lacks: a valid/ready write port, a registered read port, a re-initialisation sweep FSM and a pipelined normalisation checker.
- Sits between the gate-apply datapath (writer) and the measurement/readout logic (reader).

Parameters:
- NUM_QUBITS, 4, number of qubit entries (>=2).
- DATA_W, 16, width of each amplitude component, two's complement.
- FRAC_W, 8, fractional bits; 1.0 = 1<<FRAC_W.
- NORM_TOL, 4, allowed |norm − 1.0| in DATA_W-format LSBs.
- Derived localparam: AW = clog2(NUM_QUBITS).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- init_req  in  1  pulse: sweep all entries back to |0>.
- init_busy  out  1  sweep in progress.
- wr_valid  in  1  write request.
- wr_ready  out  1  write port can accept.
- wr_addr  in  AW  target entry.
- wr_alpha_re, wr_alpha_im, wr_beta_re, wr_beta_im  in  DATA_W each  new amplitudes.
- rd_en  in  1  read request.
- rd_addr  in  AW  entry to read.
- rd_valid  out  1  read data valid.
- rd_alpha_re, rd_alpha_im, rd_beta_re, rd_beta_im  out  DATA_W each  read data.
- norm_err  out  1  sticky normalisation-error flag.
- norm_err_addr  out  AW  address of the first failing write.
- norm_clr  in  1  clears norm_err.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low. While reset_n=0 at a clk edge:
  - every entry loads |0>: alpha_re = 1<<FRAC_W, all other components 0;
  - FSM goes to IDLE and the sweep counter to 0;
  - init_busy, rd_valid, norm_err, norm_err_addr, all rd_* data and both norm pipeline valid bits go to 0;
  - wr_ready is forced 0 combinationally while reset_n=0.
- FSM:
  - IDLE: wr_ready=1. init_req=1 moves to INIT with cnt=0.
  - INIT: wr_ready=0, init_busy=1. Each cycle entry[cnt] loads |0> and cnt increments. After entry NUM_QUBITS−1 is written, return to IDLE. The sweep takes exactly NUM_QUBITS cycles.
  - init_req while in INIT is ignored (no restart).
  - init_req and wr_valid in the same IDLE cycle: init wins and the write is not accepted (wr_ready is combinational from state and init_req, so it reads 0).
- Write port:
  - Transfer happens on an edge where wr_valid & wr_ready.
  - The entry updates at that edge and is visible to a read issued on the following cycle.
  - wr_addr >= NUM_QUBITS: transfer is accepted, storage is unchanged, no norm check is performed.
- Read port:
  - rd_en at edge T: rd_* and rd_valid=1 are valid after edge T, i.e. 1-cycle latency. rd_valid=0 on cycles without rd_en; rd_* hold their last value.
  - Read and write to the same address at the same edge: the read returns the old contents (read-before-write).
  - Reads are allowed during INIT and return current contents.
  - rd_addr >= NUM_QUBITS returns all zeros with rd_valid=1.
- Norm checker (2-stage pipeline, fed only by accepted in-range writes):
  - Stage 1 registers the four signed squares, each 2·DATA_W bits.
  - Stage 2 computes sum = Σsquares (2·DATA_W+2 bits, unsigned), then n = sum >> FRAC_W (truncating).
  - Error if |n − (1<<FRAC_W)| > NORM_TOL.
  - A write accepted at edge T sets norm_err after edge T+2.
  - On the first error while norm_err=0, norm_err_addr captures the address; later errors do not overwrite it.
  - norm_clr clears the flag. If a set and norm_clr occur on the same edge, the set wins and the address is recaptured.
- Reset mid-operation: a reset during INIT or with the pipeline full aborts the sweep, discards in-flight checks and forces all entries to |0>.

Test Plan:
- Reset then read each entry: every read returns alpha_re=0x0100, others 0x0000; rd_valid high exactly 1 cycle after each rd_en; norm_err=0.
- Write entry 2 = |+> (alpha_re=beta_re=0x00B5) then read addr 2 next cycle: 0x00B5/0/0x00B5/0. The norm check gives n=255, diff 1, so norm_err stays 0.
- Write entry 1 with alpha_re=beta_re=0x0100: norm_err=1 exactly 2 cycles after acceptance, norm_err_addr=1. A second bad write to entry 3 leaves addr=1. norm_clr on the same cycle as a third bad write leaves norm_err=1.
- Write alpha_re=0xFF00 (−1.0), others 0: the signed square is 0x10000, n=256, no error.
- Load all entries with |1> (beta_re=0x0100), pulse init_req:
  - init_busy and wr_ready=0 for exactly NUM_QUBITS cycles;
  - a wr_valid held during the sweep is accepted on the first IDLE cycle;
  - all entries read back as |0> except the written one.
- Same-edge read and write to addr 0: read returns the pre-write value. Also assert reset_n=0 mid-sweep: init_busy drops after that edge and all entries read as |0>.
